// File: rtl/entity_motion_ctrl.sv
// Entity table owner and per-frame move/collision sequencer for the player and monster.
// Optional `MONSTER_CHASE_EN: monster steers itself toward the player instead of following MONSTER_DIR.
module entity_motion_ctrl #(
    parameter int STEP = 2,
    parameter int P_X0 = 64,
    parameter int P_Y0 = 64,
    parameter int M_X0 = 192,
    parameter int M_Y0 = 128,
    parameter int G_X0 = 224,
    parameter int G_Y0 = 160,
    parameter int W_X0 = 96,
    parameter int W_Y0 = 64
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       FRAME_TICK,
    input  logic       RESTART,
    input  logic [2:0] PLAYER_DIR,
    input  logic [2:0] MONSTER_DIR,
    output logic       RUN_COLLISION,
    output logic [2:0] STOP_ADDRESS,
    output logic [1:0] MOVER_ID,
    output logic [8:0] OLD_X,
    output logic [8:0] OLD_Y,
    output logic [8:0] NEW_X,
    output logic [8:0] NEW_Y,
    input  logic [1:0] ADDRESS,
    output logic [1:0] OBJ_ID,
    output logic [8:0] OBJ_X,
    output logic [8:0] OBJ_Y,
    input  logic       COLLISION_DONE,
    input  logic [8:0] FINAL_X,
    input  logic [8:0] FINAL_Y,
    input  logic       GAME_OVER_FLAG,
    input  logic       YOU_WIN_FLAG,
    input  logic [1:0] DRAW_ADDR,
    output logic [1:0] DRAW_ID,
    output logic [8:0] DRAW_X,
    output logic [8:0] DRAW_Y,
    output logic       BUSY,
    output logic       GAME_OVER,
    output logic       YOU_WIN
);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

    state_t     state, state_nxt;
    logic [8:0] tbl_x [4];
    logic [8:0] tbl_y [4];
    logic       mover;
    logic [8:0] old_x, old_y, new_x, new_y;
    logic       blocked, go_acc, win_acc;
    logic       game_over_q, you_win_q;
    logic [2:0] dir;
    logic       mv_valid;
    logic [8:0] cur_x, cur_y, prop_x, prop_y;

    function automatic logic [8:0] sat_inc(input logic [8:0] p);
        logic [9:0] s;
        s = {1'b0, p} + 10'(STEP);
        return s[9] ? 9'd511 : s[8:0];
    endfunction

    function automatic logic [8:0] sat_dec(input logic [8:0] p);
        logic [9:0] s;
        s = {1'b0, p} - 10'(STEP);
        return s[9] ? 9'd0 : s[8:0];
    endfunction

    assign STOP_ADDRESS = 3'b100;
    assign MOVER_ID     = {1'b0, mover};
    assign OLD_X        = old_x;
    assign OLD_Y        = old_y;
    assign NEW_X        = new_x;
    assign NEW_Y        = new_y;
    assign OBJ_ID       = ADDRESS;
    assign OBJ_X        = tbl_x[ADDRESS];
    assign OBJ_Y        = tbl_y[ADDRESS];
    assign DRAW_ID      = DRAW_ADDR;
    assign DRAW_X       = tbl_x[DRAW_ADDR];
    assign DRAW_Y       = tbl_y[DRAW_ADDR];
    assign GAME_OVER    = game_over_q;
    assign YOU_WIN      = you_win_q;
    assign cur_x        = tbl_x[{1'b0, mover}];
    assign cur_y        = tbl_y[{1'b0, mover}];

`ifdef MONSTER_CHASE_EN
    logic signed [9:0] dx, dy;
    logic [9:0]        adx, ady;
`endif

    // Move proposal for the current mover
    always_comb begin
        dir = mover ? MONSTER_DIR : PLAYER_DIR;
`ifdef MONSTER_CHASE_EN
        dx  = $signed({1'b0, tbl_x[0]}) - $signed({1'b0, tbl_x[1]});
        dy  = $signed({1'b0, tbl_y[0]}) - $signed({1'b0, tbl_y[1]});
        adx = dx[9] ? $unsigned(-dx) : $unsigned(dx);
        ady = dy[9] ? $unsigned(-dy) : $unsigned(dy);
        if (mover) begin
            if (dx == 10'sd0 && dy == 10'sd0)
                dir = 3'b000;
            else if (adx >= ady)
                dir = {1'b1, dx[9] ? 2'b10 : 2'b11};
            else
                dir = {1'b1, dy[9] ? 2'b00 : 2'b01};
        end
`endif
        mv_valid = dir[2];
        prop_x   = cur_x;
        prop_y   = cur_y;
        case (dir[1:0])
            2'b00:   prop_y = sat_dec(cur_y);
            2'b01:   prop_y = sat_inc(cur_y);
            2'b10:   prop_x = sat_dec(cur_x);
            default: prop_x = sat_inc(cur_x);
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        RUN_COLLISION = 1'b0;
        BUSY          = 1'b1;
        case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (FRAME_TICK && !game_over_q && !you_win_q)
                    state_nxt = LOAD;
            end
            LOAD: begin
                if (mv_valid)
                    state_nxt = CHECK;
                else if (!mover)
                    state_nxt = LOAD;
                else
                    state_nxt = IDLE;
            end
            CHECK: begin
                RUN_COLLISION = 1'b1;
                if (COLLISION_DONE)
                    state_nxt = COMMIT;
            end
            default: begin
                state_nxt = mover ? IDLE : LOAD;
            end
        endcase
        if (RESTART)
            state_nxt = IDLE;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            tbl_x[0] <= 9'(P_X0); tbl_y[0] <= 9'(P_Y0);
            tbl_x[1] <= 9'(M_X0); tbl_y[1] <= 9'(M_Y0);
            tbl_x[2] <= 9'(G_X0); tbl_y[2] <= 9'(G_Y0);
            tbl_x[3] <= 9'(W_X0); tbl_y[3] <= 9'(W_Y0);
            mover       <= 1'b0;
            old_x       <= 9'(P_X0);
            old_y       <= 9'(P_Y0);
            new_x       <= 9'(P_X0);
            new_y       <= 9'(P_Y0);
            blocked     <= 1'b0;
            go_acc      <= 1'b0;
            win_acc     <= 1'b0;
            game_over_q <= 1'b0;
            you_win_q   <= 1'b0;
        end else if (RESTART) begin
            tbl_x[0] <= 9'(P_X0); tbl_y[0] <= 9'(P_Y0);
            tbl_x[1] <= 9'(M_X0); tbl_y[1] <= 9'(M_Y0);
            tbl_x[2] <= 9'(G_X0); tbl_y[2] <= 9'(G_Y0);
            tbl_x[3] <= 9'(W_X0); tbl_y[3] <= 9'(W_Y0);
            mover       <= 1'b0;
            old_x       <= 9'(P_X0);
            old_y       <= 9'(P_Y0);
            new_x       <= 9'(P_X0);
            new_y       <= 9'(P_Y0);
            blocked     <= 1'b0;
            go_acc      <= 1'b0;
            win_acc     <= 1'b0;
            game_over_q <= 1'b0;
            you_win_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == LOAD)
                        mover <= 1'b0;
                end
                LOAD: begin
                    old_x <= cur_x;
                    old_y <= cur_y;
                    new_x <= prop_x;
                    new_y <= prop_y;
                    if (!mv_valid && !mover)
                        mover <= 1'b1;
                end
                CHECK: begin
                    // The mover's own entry always disagrees with its proposal, so it is excluded
                    if (!COLLISION_DONE && ADDRESS != {1'b0, mover}) begin
                        if (FINAL_X != new_x || FINAL_Y != new_y)
                            blocked <= 1'b1;
                        if (GAME_OVER_FLAG)
                            go_acc <= 1'b1;
                        if (YOU_WIN_FLAG && !mover)
                            win_acc <= 1'b1;
                    end
                end
                default: begin
                    if (!blocked) begin
                        tbl_x[{1'b0, mover}] <= new_x;
                        tbl_y[{1'b0, mover}] <= new_y;
                    end
                    game_over_q <= game_over_q | go_acc;
                    you_win_q   <= you_win_q | win_acc;
                    blocked     <= 1'b0;
                    go_acc      <= 1'b0;
                    win_acc     <= 1'b0;
                    if (!mover)
                        mover <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_entity_motion_ctrl.sv
// Directed bench: three controllers (default, monster beside player, goal beside player) each paired
// with a simple collision-checker stand-in (bounds box 32..480, 26-pixel hit radius, wall blocks).
module tb_entity_motion_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       RESET = 1'b1;
    logic       FRAME_TICK = 1'b0;
    logic       RESTART = 1'b0;
    logic [2:0] PLAYER_DIR = 3'b000;
    logic [2:0] MONSTER_DIR = 3'b000;
    logic [1:0] draw_addr = 2'd0;

    logic       busy [3];
    logic       go [3];
    logic       yw [3];
    logic       run [3];
    logic [1:0] mid [3];
    logic [8:0] newx [3];
    logic [8:0] newy [3];
    logic [1:0] draw_id [3];
    logic [8:0] draw_x [3];
    logic [8:0] draw_y [3];

    int checks = 0;
    int errors = 0;
    int bcnt, rcnt, pulses, b1;

    always #10 CLOCK_50 = ~CLOCK_50;

    for (genvar g = 0; g < 3; g++) begin : inst
        logic [2:0] stop, cnt;
        logic [8:0] oldx, oldy, obj_x, obj_y, fx, fy, ax, ay;
        logic [1:0] address, obj_id;
        logic       done, gof, ywf;

        entity_motion_ctrl #(
            .M_X0(g == 1 ? 90 : 192), .M_Y0(g == 1 ? 64 : 128),
            .G_X0(g == 2 ? 90 : 224), .G_Y0(g == 2 ? 64 : 160)
        ) dut (
            .CLOCK_50(CLOCK_50), .RESET(RESET), .FRAME_TICK(FRAME_TICK), .RESTART(RESTART),
            .PLAYER_DIR(PLAYER_DIR), .MONSTER_DIR(MONSTER_DIR),
            .RUN_COLLISION(run[g]), .STOP_ADDRESS(stop), .MOVER_ID(mid[g]),
            .OLD_X(oldx), .OLD_Y(oldy), .NEW_X(newx[g]), .NEW_Y(newy[g]),
            .ADDRESS(address), .OBJ_ID(obj_id), .OBJ_X(obj_x), .OBJ_Y(obj_y),
            .COLLISION_DONE(done), .FINAL_X(fx), .FINAL_Y(fy),
            .GAME_OVER_FLAG(gof), .YOU_WIN_FLAG(ywf),
            .DRAW_ADDR(draw_addr), .DRAW_ID(draw_id[g]), .DRAW_X(draw_x[g]), .DRAW_Y(draw_y[g]),
            .BUSY(busy[g]), .GAME_OVER(go[g]), .YOU_WIN(yw[g])
        );

        always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET)
                cnt <= 3'd0;
            else if (!run[g])
                cnt <= 3'd0;
            else
                cnt <= cnt + 3'd1;
        end

        assign address = cnt[1:0];
        assign done    = (cnt == stop);

        always_comb begin
            ax  = (newx[g] >= obj_x) ? newx[g] - obj_x : obj_x - newx[g];
            ay  = (newy[g] >= obj_y) ? newy[g] - obj_y : obj_y - newy[g];
            fx  = newx[g];
            fy  = newy[g];
            gof = 1'b0;
            ywf = 1'b0;
            if (newx[g] < 9'd32 || newx[g] > 9'd480 || newy[g] < 9'd32 || newy[g] > 9'd480) begin
                fx = oldx;
                fy = oldy;
            end else if (ax <= 9'd26 && ay <= 9'd26) begin
                case (obj_id)
                    2'b11: begin fx = oldx; fy = oldy; end
                    2'b10: ywf = 1'b1;
                    default: gof = (obj_id != mid[g]);
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int g, input int a, input int ex, input int ey);
        draw_addr = 2'(a);
        #1;
        chk({tag, ".x"}, 32'(draw_x[g]), 32'(ex));
        chk({tag, ".y"}, 32'(draw_y[g]), 32'(ey));
    endtask

    // One tick; measures inst 0 busy/run activity and any inst 1 busy. extra re-ticks mid-sweep.
    task automatic sweep(input bit extra);
        int  n;
        bit  prev;
        @(negedge CLOCK_50);
        FRAME_TICK = 1'b1;
        @(negedge CLOCK_50);
        FRAME_TICK = 1'b0;
        bcnt = 0; rcnt = 0; pulses = 0; b1 = 0; prev = 1'b0; n = 0;
        do begin
            if (busy[0]) bcnt++;
            if (run[0]) rcnt++;
            if (run[0] && !prev) pulses++;
            prev = run[0];
            if (busy[1]) b1++;
            FRAME_TICK = (extra && n == 3);
            n++;
            @(negedge CLOCK_50);
        end while (busy[0] && n < 40);
        FRAME_TICK = 1'b0;
        chk("sweep_end", 32'(busy[0]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge CLOCK_50);
        RESET = 1'b0;
        @(negedge CLOCK_50);

        chk("rst.busy", 32'(busy[0]), 32'd0);
        chk("rst.run", 32'(run[0]), 32'd0);
        chk("rst.go", 32'(go[0]), 32'd0);
        chk("rst.win", 32'(yw[0]), 32'd0);
        chk("rst.mover", 32'(mid[0]), 32'd0);
        chk("rst.newx", 32'(newx[0]), 32'd64);
        chk("rst.newy", 32'(newy[0]), 32'd64);
        chk_pos("rst.p", 0, 0, 64, 64);
        chk_pos("rst.m", 0, 1, 192, 128);
        chk_pos("rst.g", 0, 2, 224, 160);
        chk_pos("rst.w", 0, 3, 96, 64);
        chk("rst.gid", 32'(draw_id[0]), 32'd3);

        // Player right, monster idle
        PLAYER_DIR = 3'b111;
        MONSTER_DIR = 3'b000;
        sweep(1'b0);
        chk("t1.busy_cycles", 32'(bcnt), 32'd8);
        chk("t1.run_cycles", 32'(rcnt), 32'd5);
        chk("t1.run_pulses", 32'(pulses), 32'd1);
        chk_pos("t1.p", 0, 0, 66, 64);
        chk_pos("t1.m", 0, 1, 192, 128);
        chk("go.flag", 32'(go[1]), 32'd1);
        chk_pos("go.p", 1, 0, 66, 64);
        chk("win.flag", 32'(yw[2]), 32'd1);
        chk("win.go", 32'(go[2]), 32'd0);
        chk_pos("win.p", 2, 0, 66, 64);

        sweep(1'b0);
        chk_pos("t2.p", 0, 0, 68, 64);
        chk("go.frozen_busy", 32'(b1), 32'd0);
        sweep(1'b0);
        chk_pos("t3.wall_block", 0, 0, 68, 64);
        chk_pos("go.frozen_pos", 1, 0, 66, 64);

        // Player up; a second tick during the first sweep must be dropped
        PLAYER_DIR = 3'b100;
        sweep(1'b1);
        chk("drop.busy_cycles", 32'(bcnt), 32'd8);
        bcnt = 0;
        repeat (4) begin
            if (busy[0]) bcnt++;
            @(negedge CLOCK_50);
        end
        chk("drop.idle_after", 32'(bcnt), 32'd0);
        chk_pos("drop.p", 0, 0, 68, 62);
        repeat (15) sweep(1'b0);
        chk_pos("up16.p", 0, 0, 68, 32);
        sweep(1'b0);
        chk_pos("up17.bound", 0, 0, 68, 32);

        @(negedge CLOCK_50);
        RESTART = 1'b1;
        @(negedge CLOCK_50);
        RESTART = 1'b0;
        chk_pos("restart.p", 0, 0, 64, 64);
        chk("restart.go", 32'(go[1]), 32'd0);
        chk("restart.win", 32'(yw[2]), 32'd0);
        chk_pos("restart.m1", 1, 1, 90, 64);

        // Monster walks onto the goal; no win for the monster
        PLAYER_DIR = 3'b000;
        MONSTER_DIR = 3'b111;
        repeat (3) sweep(1'b0);
        chk("mon.busy_cycles", 32'(bcnt), 32'd8);
        chk_pos("mon.right", 0, 1, 198, 128);
        MONSTER_DIR = 3'b101;
        repeat (3) sweep(1'b0);
        chk_pos("mon.goal", 0, 1, 198, 134);
        chk_pos("mon.p", 0, 0, 64, 64);
        chk("mon.win", 32'(yw[0]), 32'd0);
        chk("mon.go", 32'(go[0]), 32'd0);

        // Asynchronous reset in the middle of CHECK
        PLAYER_DIR = 3'b111;
        MONSTER_DIR = 3'b000;
        @(negedge CLOCK_50);
        FRAME_TICK = 1'b1;
        @(negedge CLOCK_50);
        FRAME_TICK = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("mid.run_before", 32'(run[0]), 32'd1);
        #3;
        RESET = 1'b1;
        #1;
        chk("mid.run_async", 32'(run[0]), 32'd0);
        chk("mid.busy", 32'(busy[0]), 32'd0);
        chk_pos("mid.p", 0, 0, 64, 64);
        chk_pos("mid.m", 0, 1, 192, 128);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        @(negedge CLOCK_50);
        chk("mid.idle", 32'(busy[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
